ws2812_serializer: RTL and testbench

WS2812_SERIALIZER -- requirements
Module: ws2812_serializer

---
 rtl/ws2812_serializer_pkg.sv | 21 ++
 rtl/ws2812_bit_encoder.sv | 19 +
 rtl/ws2812_serializer.sv | 167 ++++++++++++++++
 tb/tb_ws2812_serializer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/ws2812_serializer_pkg.sv
// Shared definitions for the WS2812 serializer: FSM state encoding and pixel/segment geometry.
package ws2812_serializer_pkg;

  localparam int PIXEL_BITS       = 24;
  localparam int SEGMENTS_PER_BIT = 3;
  localparam int BIT_IDX_W        = $clog2(PIXEL_BITS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_LATCH = 2'd3
  } state_t;

  typedef logic [1:0]           seg_idx_t;
  typedef logic [BIT_IDX_W-1:0] bit_idx_t;

  localparam seg_idx_t SEG_LAST = seg_idx_t'(SEGMENTS_PER_BIT - 1);
  localparam bit_idx_t BIT_LAST = bit_idx_t'(PIXEL_BITS - 1);

endpackage

// File: rtl/ws2812_bit_encoder.sv
// Maps one data bit and a segment index to the line level: segment0 high, segment1 the bit, segment2 low.
module ws2812_bit_encoder
  import ws2812_serializer_pkg::*;
(
  input  logic     data_bit,
  input  seg_idx_t segment_index,
  output logic     level
);

  always_comb begin
    level = 1'b0;
    case (segment_index)
      2'd0:    level = 1'b1;
      2'd1:    level = data_bit;
      default: level = 1'b0;
    endcase
  end

endmodule

// File: rtl/ws2812_serializer.sv
// WS2812 frame serializer: pulls GRB pixels, emits three segments per bit, then a low latch period.
// Optional feature: define UNDERRUN_COUNT_EN to add the saturating underrun_count output.
module ws2812_serializer
  import ws2812_serializer_pkg::*;
#(
  parameter int LED_COUNT      = 8,
  parameter int LATCH_SEGMENTS = 200
) (
  input  logic                  clock_12mhz,
  input  logic                  reset,
  input  logic                  bit_segment_strobe,
  input  logic                  framerate,
  input  logic [PIXEL_BITS-1:0] pixel_data,
  input  logic                  pixel_valid,
  output logic                  pixel_ready,
  output logic                  data_out,
  output logic                  busy,
  output logic                  frame_done
`ifdef UNDERRUN_COUNT_EN
  ,
  output logic [7:0]            underrun_count
`endif
);

  localparam int PIX_W   = $clog2(LED_COUNT + 1);
  localparam int LATCH_W = $clog2(LATCH_SEGMENTS + 1);

  localparam logic [PIX_W-1:0]   PIXEL_LAST = PIX_W'(LED_COUNT - 1);
  localparam logic [LATCH_W-1:0] LATCH_LAST = LATCH_W'(LATCH_SEGMENTS - 1);

  state_t                  state_reg, state_next;
  logic [PIXEL_BITS-1:0]   shift_reg;
  seg_idx_t                seg_cnt_reg;
  bit_idx_t                bit_cnt_reg;
  logic [PIX_W-1:0]        pixel_cnt_reg;
  logic [LATCH_W-1:0]      latch_cnt_reg;
  logic                    data_out_reg;
  logic                    frame_done_reg;

  logic                    start_frame;
  logic                    capture;
  logic                    latch_end;
  logic [PIXEL_BITS-1:0]   capture_word;
  logic                    enc_bit;
  seg_idx_t                enc_seg;
  logic                    enc_level;

  // An invalid pixel at the accept strobe becomes black rather than stalling the line.
  assign capture_word = pixel_valid ? pixel_data : '0;

  always_ff @(posedge clock_12mhz or negedge reset) begin
    if (!reset) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next  = state_reg;
    pixel_ready = 1'b0;
    start_frame = 1'b0;
    capture     = 1'b0;
    latch_end   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (framerate) begin
          start_frame = 1'b1;
          state_next  = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (bit_segment_strobe) begin
          pixel_ready = 1'b1;
          capture     = 1'b1;
          state_next  = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (bit_segment_strobe && seg_cnt_reg == SEG_LAST && bit_cnt_reg == '0)
          state_next = (pixel_cnt_reg == PIXEL_LAST) ? ST_LATCH : ST_LOAD;
      end
      ST_LATCH: begin
        if (bit_segment_strobe && latch_cnt_reg == LATCH_LAST) begin
          latch_end  = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // The accept strobe already emits segment0 of the new MSB, so the encoder sees the incoming word.
  assign enc_bit = capture ? capture_word[PIXEL_BITS-1] : shift_reg[PIXEL_BITS-1];
  assign enc_seg = capture ? seg_idx_t'(0) : seg_cnt_reg;

  ws2812_bit_encoder u_bit_encoder (
    .data_bit      (enc_bit),
    .segment_index (enc_seg),
    .level         (enc_level)
  );

  always_ff @(posedge clock_12mhz or negedge reset) begin
    if (!reset) begin
      shift_reg      <= '0;
      seg_cnt_reg    <= '0;
      bit_cnt_reg    <= '0;
      pixel_cnt_reg  <= '0;
      latch_cnt_reg  <= '0;
      data_out_reg   <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      frame_done_reg <= latch_end;

      if (bit_segment_strobe && (capture || state_reg == ST_SHIFT))
        data_out_reg <= enc_level;
      else if (state_reg == ST_IDLE || state_reg == ST_LATCH)
        data_out_reg <= 1'b0;

      if (start_frame) begin
        pixel_cnt_reg <= '0;
        latch_cnt_reg <= '0;
      end

      if (capture) begin
        shift_reg   <= capture_word;
        seg_cnt_reg <= seg_idx_t'(1);
        bit_cnt_reg <= BIT_LAST;
      end else if (state_reg == ST_SHIFT && bit_segment_strobe) begin
        if (seg_cnt_reg == SEG_LAST) begin
          seg_cnt_reg <= '0;
          if (bit_cnt_reg == '0) begin
            pixel_cnt_reg <= pixel_cnt_reg + 1'b1;
          end else begin
            bit_cnt_reg <= bit_cnt_reg - 1'b1;
            shift_reg   <= {shift_reg[PIXEL_BITS-2:0], 1'b0};
          end
        end else begin
          seg_cnt_reg <= seg_cnt_reg + 1'b1;
        end
      end

      if (state_reg == ST_LATCH && bit_segment_strobe) begin
        if (latch_end) latch_cnt_reg <= '0;
        else           latch_cnt_reg <= latch_cnt_reg + 1'b1;
      end
    end
  end

`ifdef UNDERRUN_COUNT_EN
  logic [7:0] underrun_count_reg;

  always_ff @(posedge clock_12mhz or negedge reset) begin
    if (!reset) begin
      underrun_count_reg <= '0;
    end else if (start_frame) begin
      underrun_count_reg <= '0;
    end else if (capture && !pixel_valid && underrun_count_reg != 8'hFF) begin
      underrun_count_reg <= underrun_count_reg + 8'd1;
    end
  end

  assign underrun_count = underrun_count_reg;
`endif

  assign busy       = (state_reg != ST_IDLE);
  assign data_out   = data_out_reg;
  assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_ws2812_serializer.sv
// Directed bench for ws2812_serializer: 3-pixel frame with underrun, ignored framerate, mid-frame reset.
module tb_ws2812_serializer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        strobe = 1'b0;
  logic        framerate = 1'b0;
  logic [23:0] pixel_data = '0;
  logic        pixel_valid = 1'b0;
  logic        pixel_ready;
  logic        data_out;
  logic        busy;
  logic        frame_done;
`ifdef UNDERRUN_COUNT_EN
  logic [7:0]  underrun_count;
`endif

  ws2812_serializer #(
    .LED_COUNT      (3),
    .LATCH_SEGMENTS (200)
  ) dut (
    .clock_12mhz        (clk),
    .reset              (rst_n),
    .bit_segment_strobe (strobe),
    .framerate          (framerate),
    .pixel_data         (pixel_data),
    .pixel_valid        (pixel_valid),
    .pixel_ready        (pixel_ready),
    .data_out           (data_out),
    .busy               (busy),
    .frame_done         (frame_done)
`ifdef UNDERRUN_COUNT_EN
    ,
    .underrun_count     (underrun_count)
`endif
  );

  always #5 clk = ~clk;

  logic [23:0] pix_tab [4] = '{24'h800001, 24'hA53C0F, 24'hFFFFFF, 24'h000000};
  logic        val_tab [4] = '{1'b1, 1'b1, 1'b0, 1'b1};

  int   checks = 0;
  int   errors = 0;
  int   phase = 0;
  int   ready_cnt = 0;
  int   done_cnt = 0;
  int   ready_base = 0;
  logic rec_en = 1'b0;
  logic strobe_d = 1'b0;
  logic segs [$];
  logic exp_segs [$];

  // Sample away from the active edge: counts and the segment stream one cycle after each strobe.
  always @(negedge clk) begin
    if (pixel_ready === 1'b1) ready_cnt <= ready_cnt + 1;
    if (frame_done === 1'b1)  done_cnt  <= done_cnt + 1;
    if (rec_en && strobe_d)   segs.push_back(data_out);
    strobe_d <= strobe;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic cyc();
    int idx;
    @(posedge clk);
    #1;
    framerate = 1'b0;
    phase  = (phase == 4) ? 0 : phase + 1;
    strobe = (phase == 4);
    idx = ready_cnt - ready_base;
    if (idx > 3) idx = 3;
    if (idx < 0) idx = 0;
    pixel_data  = pix_tab[idx];
    pixel_valid = val_tab[idx];
    #1;
  endtask

  task automatic wait_strobe();
    int n = 0;
    cyc();
    while (strobe !== 1'b1 && n < 10) begin
      cyc();
      n++;
    end
  endtask

  // Raise framerate in a strobe cycle so that strobe must be treated as unused.
  task automatic fire_frame(input logic rec);
    int n = 0;
    while (strobe !== 1'b1 && n < 10) begin
      cyc();
      n++;
    end
    ready_base = ready_cnt;
    framerate  = 1'b1;
    rec_en     = rec;
    #1;
    check("ready_on_framerate_strobe", {31'd0, pixel_ready}, 32'd0);
  endtask

  initial begin
    int n;
    int mism;
    int activity;
    int base;
    logic [23:0] w;

    repeat (3) cyc();
    check("rst_data_out", {31'd0, data_out}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_pixel_ready", {31'd0, pixel_ready}, 32'd0);
    check("rst_frame_done", {31'd0, frame_done}, 32'd0);
    rst_n = 1'b1;
    repeat (20) cyc();
    check("idle_without_framerate", {31'd0, busy}, 32'd0);
    $display("step reset: checks=%0d", checks);

    // Frame 1: pixels 800001, A53C0F, then an underrun (data present but invalid).
    fire_frame(1'b1);
    wait_strobe();
    check("ready_on_next_strobe", {31'd0, pixel_ready}, 32'd1);
    check("busy_in_load", {31'd0, busy}, 32'd1);
    n = 0;
    while (done_cnt == 0 && n < 4000) begin
      cyc();
      n++;
      if (n == 100 || n == 1500) begin
        check("busy_at_ignored_framerate", {31'd0, busy}, 32'd1);
        framerate = 1'b1;
      end
    end
    rec_en = 1'b0;
    check("frame_done_seen", done_cnt, 32'd1);
    check("frame_done_one_cycle", {31'd0, frame_done}, 32'd0);
    check("busy_after_frame", {31'd0, busy}, 32'd0);
    check("ready_pulses", ready_cnt - ready_base, 32'd3);
    check("segment_count", segs.size(), 32'd417);

    exp_segs.delete();
    exp_segs.push_back(1'b0);
    for (int p = 0; p < 3; p++) begin
      w = val_tab[p] ? pix_tab[p] : 24'h000000;
      for (int b = 23; b >= 0; b--) begin
        exp_segs.push_back(1'b1);
        exp_segs.push_back(w[b]);
        exp_segs.push_back(1'b0);
      end
    end
    repeat (200) exp_segs.push_back(1'b0);

    for (int p = 0; p < 3; p++) begin
      mism = 0;
      for (int i = 1 + p * 72; i < 73 + p * 72; i++)
        if (i >= segs.size() || segs[i] !== exp_segs[i]) mism++;
      check($sformatf("pixel%0d_stream_mismatches", p), mism, 32'd0);
    end
    mism = 0;
    for (int i = 217; i < 417; i++)
      if (i >= segs.size() || segs[i] !== 1'b0) mism++;
    check("latch_low_segments", mism, 32'd0);
    if (segs.size() >= 417) begin
      check("p0_bit23", {29'd0, segs[1], segs[2], segs[3]}, 32'b110);
      check("p0_bit22", {29'd0, segs[4], segs[5], segs[6]}, 32'b100);
      check("p0_bit0", {29'd0, segs[70], segs[71], segs[72]}, 32'b110);
      check("p1_bit23", {29'd0, segs[73], segs[74], segs[75]}, 32'b110);
      check("p2_underrun_bit23", {29'd0, segs[145], segs[146], segs[147]}, 32'b100);
    end else begin
      check("stream_too_short", segs.size(), 32'd417);
    end
`ifdef UNDERRUN_COUNT_EN
    check("underrun_count", {24'd0, underrun_count}, 32'd1);
`endif
    repeat (100) cyc();
    check("single_frame_only", done_cnt, 32'd1);
    check("no_extra_ready", ready_cnt - ready_base, 32'd3);
    $display("step frame: segments=%0d readies=%0d checks=%0d", segs.size(), ready_cnt - ready_base, checks);

    // Frame 2: reset while bit 12 is on the line (segment0, line high).
    fire_frame(1'b0);
    n = 0;
    base = 0;
    while (base < 34 && n < 400) begin
      cyc();
      n++;
      if (strobe === 1'b1) base++;
    end
    cyc();
    check("bit12_seg0_high", {31'd0, data_out}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("midreset_data_out", {31'd0, data_out}, 32'd0);
    check("midreset_busy", {31'd0, busy}, 32'd0);
    check("midreset_frame_done", {31'd0, frame_done}, 32'd0);
    repeat (3) cyc();
    rst_n = 1'b1;
    base = ready_cnt;
    activity = 0;
    repeat (300) begin
      cyc();
      if (data_out !== 1'b0 || busy !== 1'b0 || pixel_ready !== 1'b0) activity++;
    end
    check("quiet_after_reset", activity, 32'd0);
    check("no_ready_after_reset", ready_cnt - base, 32'd0);
    $display("step midreset: checks=%0d", checks);

    // Recovery: a fresh framerate starts a new frame normally.
    fire_frame(1'b0);
    wait_strobe();
    check("recover_ready", {31'd0, pixel_ready}, 32'd1);
    check("recover_busy", {31'd0, busy}, 32'd1);
    $display("step recover: checks=%0d", checks);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
